// File: rtl/serial_mag_compare_if.sv
// Operand/result handshake bundle for serial_mag_compare.
// The master side is the producer/consumer; the slave side is the comparator.
interface serial_mag_compare_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic             gt;
    logic             lt;
    logic             eq;
    logic             busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, gt, lt, eq, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, gt, lt, eq, busy
    );
endinterface

// File: rtl/serial_mag_compare.sv
// Bit-serial unsigned magnitude comparator, MSB first, sticky decision.
// Optional macro SERIAL_MAG_COMPARE_EARLY_EXIT_EN ends the scan at the first differing bit.
module serial_mag_compare #(
    parameter int WIDTH = 8
) (
    input logic                 clk,
    input logic                 rst,
    serial_mag_compare_if.slave bus
);
    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] sa_r, sa_s;
    logic [WIDTH-1:0] sb_r, sb_s;
    logic [IDX_W-1:0] idx_r, idx_s;
    logic             gt_r, gt_s;
    logic             lt_r, lt_s;
    logic [1:0]       hit_s;
    logic             early_exit_s;

    logic             in_ready_r, in_ready_s;
    logic             out_valid_r, out_valid_s;
    logic             gt_out_r, gt_out_s;
    logic             lt_out_r, lt_out_s;
    logic             eq_out_r, eq_out_s;
    logic             busy_r, busy_s;

    // Returns {set_gt, set_lt} for one bit position; nothing is set once a decision exists.
    function automatic logic [1:0] bit_decide(input logic a_bit, input logic b_bit,
                                              input logic decided);
        logic [1:0] res;
        if (decided) begin
            res = 2'b00;
        end else begin
            res = {a_bit & ~b_bit, ~a_bit & b_bit};
        end
        return res;
    endfunction

    // Next-state, datapath and registered-output precompute.
    always_comb begin
        state_s      = state_r;
        sa_s         = sa_r;
        sb_s         = sb_r;
        idx_s        = idx_r;
        gt_s         = gt_r;
        lt_s         = lt_r;
        hit_s        = bit_decide(sa_r[WIDTH-1], sb_r[WIDTH-1], gt_r | lt_r);
`ifdef SERIAL_MAG_COMPARE_EARLY_EXIT_EN
        early_exit_s = hit_s[1] | hit_s[0];
`else
        early_exit_s = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (bus.in_valid && in_ready_r) begin
                    sa_s    = bus.a;
                    sb_s    = bus.b;
                    idx_s   = IDX_W'(WIDTH - 1);
                    gt_s    = 1'b0;
                    lt_s    = 1'b0;
                    state_s = SCAN;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                gt_s = gt_r | hit_s[1];
                lt_s = lt_r | hit_s[0];
                sa_s = {sa_r[WIDTH-2:0], 1'b0};
                sb_s = {sb_r[WIDTH-2:0], 1'b0};
                // Hold at zero on exit so the counter never wraps.
                if (idx_r == IDX_W'(0)) begin
                    idx_s   = IDX_W'(0);
                    state_s = DONE;
                end else if (early_exit_s) begin
                    idx_s   = idx_r - IDX_W'(1);
                    state_s = DONE;
                end else begin
                    idx_s   = idx_r - IDX_W'(1);
                    state_s = SCAN;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        in_ready_s  = (state_s == IDLE);
        busy_s      = (state_s == SCAN);
        out_valid_s = (state_s == DONE);
        gt_out_s    = out_valid_s & gt_s;
        lt_out_s    = out_valid_s & lt_s;
        eq_out_s    = out_valid_s & ~gt_s & ~lt_s;
    end

    // State, datapath and output registers with asynchronous abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            sa_r        <= {WIDTH{1'b0}};
            sb_r        <= {WIDTH{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            gt_r        <= 1'b0;
            lt_r        <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            gt_out_r    <= 1'b0;
            lt_out_r    <= 1'b0;
            eq_out_r    <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            sa_r        <= sa_s;
            sb_r        <= sb_s;
            idx_r       <= idx_s;
            gt_r        <= gt_s;
            lt_r        <= lt_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            gt_out_r    <= gt_out_s;
            lt_out_r    <= lt_out_s;
            eq_out_r    <= eq_out_s;
            busy_r      <= busy_s;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.gt        = gt_out_r;
    assign bus.lt        = lt_out_r;
    assign bus.eq        = eq_out_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_serial_mag_compare.sv
// Self-checking bench for serial_mag_compare: directed table, corner sequences, random vs. model.
module tb_serial_mag_compare;
    localparam int W   = 8;
    localparam int LIM = 3 * W;

    logic clk;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    serial_mag_compare_if #(.WIDTH(W)) sif ();

    serial_mag_compare #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         gt;
        logic         lt;
        logic         eq;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference latency: cycles from accept to result, from the scan rules.
    function automatic int exp_latency(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SERIAL_MAG_COMPARE_EARLY_EXIT_EN
        for (int i = W - 1; i >= 0; i--) begin
            if (x[i] != y[i]) return W - i;
        end
        return W;
`else
        return W;
`endif
    endfunction

    // One full transaction with out_ready high; optionally scrambles a/b mid-scan.
    task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic eg, input logic el, input logic ee, input int scramble_at);
        int j;
        j = 0;
        while (!sif.in_ready && j < LIM) begin
            @(negedge clk);
            j++;
        end
        check({name, "_in_ready_before"}, sif.in_ready, 1);
        sif.a         = x;
        sif.b         = y;
        sif.in_valid  = 1'b1;
        sif.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sif.in_valid = 1'b0;
        check({name, "_busy"}, sif.busy, 1);
        j = 0;
        while (!sif.out_valid && j < LIM) begin
            if (j == scramble_at) begin
                sif.a = W'($urandom);
                sif.b = W'($urandom);
            end
            @(negedge clk);
            j++;
        end
        check({name, "_latency"}, j, exp_latency(x, y));
        check({name, "_gt"}, sif.gt, eg);
        check({name, "_lt"}, sif.lt, el);
        check({name, "_eq"}, sif.eq, ee);
        check({name, "_onehot"}, int'(sif.gt) + int'(sif.lt) + int'(sif.eq), 1);
        @(negedge clk);
        check({name, "_consumed_valid"}, sif.out_valid, 0);
        check({name, "_consumed_ready"}, sif.in_ready, 1);
    endtask

    vec_t vecs[7];

    initial begin
        logic [W-1:0] x, y;
        int           seen;

        vecs[0] = '{a: 8'hA5, b: 8'h3C, gt: 1'b1, lt: 1'b0, eq: 1'b0};
        vecs[1] = '{a: 8'h10, b: 8'h11, gt: 1'b0, lt: 1'b1, eq: 1'b0};
        vecs[2] = '{a: 8'h00, b: 8'h00, gt: 1'b0, lt: 1'b0, eq: 1'b1};
        vecs[3] = '{a: 8'h00, b: 8'hFF, gt: 1'b0, lt: 1'b1, eq: 1'b0};
        vecs[4] = '{a: 8'hFF, b: 8'h00, gt: 1'b1, lt: 1'b0, eq: 1'b0};
        vecs[5] = '{a: 8'hFF, b: 8'hFF, gt: 1'b0, lt: 1'b0, eq: 1'b1};
        vecs[6] = '{a: 8'h7F, b: 8'h80, gt: 1'b0, lt: 1'b1, eq: 1'b0};

        rst           = 1'b1;
        sif.in_valid  = 1'b0;
        sif.a         = '0;
        sif.b         = '0;
        sif.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", sif.in_ready, 1);
        check("reset_out_valid", sif.out_valid, 0);
        check("reset_gt", sif.gt, 0);
        check("reset_lt", sif.lt, 0);
        check("reset_eq", sif.eq, 0);
        check("reset_busy", sif.busy, 0);

        // Directed table, back-to-back.
        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                   vecs[i].gt, vecs[i].lt, vecs[i].eq, -1);
        end

        // Backpressure with equal all-ones operands.
        sif.a = 8'hFF; sif.b = 8'hFF; sif.in_valid = 1'b1; sif.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        sif.in_valid = 1'b0;
        seen = 0;
        while (!sif.out_valid && seen < LIM) begin
            @(negedge clk);
            seen++;
        end
        check("bp_latency", seen, W);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_valid%0d", i), sif.out_valid, 1);
            check($sformatf("bp_eq%0d", i), sif.eq, 1);
            check($sformatf("bp_in_ready%0d", i), sif.in_ready, 0);
            @(negedge clk);
        end
        sif.out_ready = 1'b1;
        check("bp_ready_before_edge", sif.in_ready, 0);
        @(negedge clk);
        check("bp_released_valid", sif.out_valid, 0);
        check("bp_released_ready", sif.in_ready, 1);

        // Operands changed three cycles into the scan.
        run_op("midchange", 8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 3);

        // Reset pulse four cycles into a scan aborts it.
        sif.a = 8'h01; sif.b = 8'h00; sif.in_valid = 1'b1; sif.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sif.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_in_ready", sif.in_ready, 1);
        check("abort_busy", sif.busy, 0);
        check("abort_out_valid", sif.out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (2 * W) begin
            @(negedge clk);
            if (sif.out_valid) seen++;
        end
        check("abort_no_result", seen, 0);
        run_op("after_abort", 8'h3C, 8'hA5, 1'b0, 1'b1, 1'b0, -1);

        // Random operands against the arithmetic model.
        for (int i = 0; i < 60; i++) begin
            x = W'($urandom);
            case ($urandom_range(0, 3))
                0:       y = x;
                1:       y = x ^ (W'(1) << $urandom_range(0, W - 1));
                default: y = W'($urandom);
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op($sformatf("rnd%0d", i), x, y, x > y, x < y, x == y, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_mag_compare.md
Name: serial_mag_compare

Overview:
- Bit-serial unsigned magnitude comparator. Captures two WIDTH-bit operands and resolves a>b, a<b and a==b by scanning one bit per clock, MSB first, with a sticky decision.
- It is the sequential, multi-bit counterpart of the team's single-bit combinational greater-than cell.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8: operand width in bits; legal range is WIDTH >= 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  the producer presents an operand pair.
- in_ready  output  1  the block can accept an operand pair.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- out_valid  output  1  the result fields are valid.
- out_ready  input  1  the consumer accepts the result.
- gt  output  1  a > b.
- lt  output  1  a < b.
- eq  output  1  a == b.
- busy  output  1  the block is scanning (state SCAN).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, gt=0, lt=0, eq=0, busy=0. Operand registers and bit index are cleared to 0.
- Reset asserted mid-operation: the operation is aborted immediately and no result is ever presented for it.
- Internal state:
  - Operand shift registers sa and sb.
  - Bit counter idx, $clog2(WIDTH) bits wide.
  - Sticky flags gt_r and lt_r.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at a clock edge: sa<=a, sb<=b, idx<=WIDTH-1, gt_r<=0, lt_r<=0, go to SCAN.
- SCAN (in_ready=0, busy=1), each cycle:
  - Compare sa[MSB] against sb[MSB].
  - If neither flag is set: if sa[MSB]=1 and sb[MSB]=0, set gt_r; if sa[MSB]=0 and sb[MSB]=1, set lt_r.
  - Once either flag is set it is frozen; lower bits are ignored.
  - Shift sa and sb left by 1 and decrement idx.
  - When the cycle processing idx==0 completes, go to DONE.
  - The counter never wraps: leaving SCAN happens exactly at idx==0.
- DONE:
  - out_valid=1, gt=gt_r, lt=lt_r, eq=~gt_r & ~lt_r.
  - Exactly one of gt, lt, eq is 1 whenever out_valid=1.
  - Results are held stable until out_valid & out_ready. On that edge, go to IDLE.
  - in_ready=0 in DONE: no new operand pair is accepted in the same cycle the result is consumed.
- Outputs outside DONE: out_valid=0 and gt, lt, eq are driven 0.
- Latency (without the optional feature):
  - If accepted at edge k, SCAN occupies edges k+1 .. k+WIDTH.
  - out_valid rises after edge k+WIDTH and stays high until it is consumed.
- Throughput: one comparison per WIDTH+2 cycles minimum, with out_ready held high.
- Input stability: a and b are ignored in all states except IDLE; changing them mid-scan has no effect.
- Operands are unsigned only. The all-zero pair and the all-ones pair both give eq=1.

Optional Feature:
- Macro: SERIAL_MAG_COMPARE_EARLY_EXIT_EN.
- Defined:
  - SCAN moves to DONE on the edge where the first differing bit sets gt_r or lt_r.
  - Latency becomes (WIDTH - index of the highest differing bit) cycles.
  - Equal operands still take WIDTH cycles.
- Undefined: SCAN always lasts exactly WIDTH cycles, independent of the data (constant-time behaviour).

Test Plan:
- Reset and idle: hold rst, then release -> in_ready=1, out_valid=0, gt/lt/eq=0, busy=0.
- Greater-than, WIDTH=8: a=8'hA5, b=8'h3C, out_ready=1 -> gt=1, lt=0, eq=0. Without the macro out_valid appears 8 cycles after accept; with it, 1 cycle after accept.
- Less-than in the LSB only: a=8'h10, b=8'h11 -> lt=1. out_valid appears 8 cycles after accept with or without the macro.
- Equality and backpressure: a=b=8'hFF with out_ready=0 for 5 cycles -> eq=1. out_valid and eq stay stable for all 5 cycles. in_ready stays 0 until the edge after out_ready=1, then becomes 1.
- Mid-scan changes: change a and b 3 cycles after accepting a=8'h80, b=8'h7F -> result is still gt=1. Separately, pulse rst 4 cycles into a scan -> state returns to IDLE, out_valid never asserts for the aborted operation, and the next pair is accepted normally.
- Back-to-back and boundaries: 8'h00 vs 8'h00 -> eq=1; then 8'h00 vs 8'hFF -> lt=1; then 8'hFF vs 8'h00 -> gt=1. Each result is consumed on first presentation, and exactly one of gt/lt/eq is high per result.
